// File: rtl/rv_pkg.sv
// Shared constants and types for the instruction fetch stage.
package rv_pkg;

  localparam logic [31:0] NOP              = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue of {pc, instr} pairs. Flush wins over push and pop.
// DEPTH must be a power of two so the pointers wrap on their own.
module fetch_fifo
  import rv_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          flush_i,
  input  logic [63:0]   push_data_i,
  output logic [63:0]   head_data_o,
  output logic [CW-1:0] count_o,
  output logic          empty_o,
  output logic          full_o
);

  localparam logic [CW-1:0] FULL_COUNT = DEPTH[CW-1:0];

  logic [63:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push, do_pop;

  assign empty_o     = (count_q == '0);
  assign full_o      = (count_q == FULL_COUNT);
  assign count_o     = count_q;
  assign head_data_o = mem_q[rd_ptr_q];
  assign do_push     = push_i && !full_o && !flush_i;
  assign do_pop      = pop_i && !empty_o && !flush_i;

  // Entry storage; no reset needed since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues one word read at a time and
// hands buffered {pc, instr} pairs to decode. Redirects flush and refetch.
//
// state | meaning
// IDLE  | no request outstanding; issue one when the queue has room
// REQ   | request outstanding; ack data is pushed into the queue
// DROP  | request outstanding after a redirect; ack data is discarded
module fetch_unit
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        id_ready,
  output logic        instr_valid,
  output logic [31:0] instruction,
  output logic [31:0] pc_out,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e  state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   pending_pc_q, pending_pc_d;
  logic [31:0]   redir_pc;
  logic          push, pop;
  logic [63:0]   head_data;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty, fifo_full;

  assign redir_pc = {redirect_pc[31:2], 2'b00};

  // The outstanding address is fetch_pc_q itself; it only moves once the
  // request has been acked, so it stays stable through REQ and DROP.
  assign imem_req  = (state_q != IDLE);
  assign imem_addr = fetch_pc_q;

  // An entry shown during a redirect cycle is flushed, not consumed.
  assign pop         = !fifo_empty && id_ready && !redirect;
  assign instr_valid = (fifo_count != '0);
  assign instruction = fifo_empty ? NOP   : head_data[31:0];
  assign pc_out      = fifo_empty ? '0    : head_data[63:32];

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .pop_i       (pop),
    .flush_i     (redirect),
    .push_data_i ({fetch_pc_q, imem_rdata}),
    .head_data_o (head_data),
    .count_o     (fifo_count),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full)
  );

  // State, fetch PC and parked redirect target.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      fetch_pc_q   <= RESET_PC;
      pending_pc_q <= '0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      pending_pc_q <= pending_pc_d;
    end
  end

  // Next-state, PC update and push decision.
  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    pending_pc_d = pending_pc_q;
    push         = 1'b0;
    case (state_q)
      IDLE: begin
        if (redirect)        fetch_pc_d = redir_pc;
        else if (!fifo_full) state_d    = REQ;
      end
      REQ: begin
        if (redirect) begin
          if (imem_ack) begin
            fetch_pc_d = redir_pc;
            state_d    = IDLE;
          end else begin
            pending_pc_d = redir_pc;
            state_d      = DROP;
          end
        end else if (imem_ack) begin
          push       = 1'b1;
          fetch_pc_d = fetch_pc_q + 32'd4;
          state_d    = IDLE;
        end
      end
      DROP: begin
        // A redirect landing with the ack is the newest target.
        if (imem_ack) begin
          fetch_pc_d = redirect ? redir_pc : pending_pc_q;
          state_d    = IDLE;
        end else if (redirect) begin
          pending_pc_d = redir_pc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
